// File: rtl/eth_frame_sequencer.sv
// Byte-position sequencer for the Ethernet packet detector: tags each accepted
// byte with a one-hot field strobe and qualifies type/length and payload size.
module eth_frame_sequencer #(
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter logic [15:0] ETYPE_MIN   = 16'h0600,
  parameter int          CNT_W       = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             control,
  input  logic [7:0]       data,
  output logic [7:0]       data_out,
  output logic             dst_en,
  output logic             src_en,
  output logic             type_en,
  output logic             payload_en,
  output logic             type_length_valid,
  output logic             packet_size_valid,
  output logic             frame_done,
  output logic             frame_error,
  output logic [CNT_W-1:0] payload_count
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PAYLOAD);
  localparam logic [15:0]      MAX_TL   = 16'(MAX_PAYLOAD);
  localparam logic [3:0]       LAST_DST = 4'd5;
  localparam logic [3:0]       LAST_SRC = 4'd11;
  localparam logic [3:0]       TYPE_HI  = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    SRC,
    TYPE,
    PAYLOAD,
    DROP
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       hdr_cnt_q, hdr_cnt_d;
  logic [15:0]      tl_q, tl_d;
  logic             len_mode_q, len_mode_d;
  logic [7:0]       data_q, data_d;
  logic             dst_q, dst_d;
  logic             src_q, src_d;
  logic             type_q, type_d;
  logic             pay_q, pay_d;
  logic             tlv_q, tlv_d;
  logic             psv_q, psv_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0] tl_full;
  logic        size_ok;

  // The low type/length byte is combined with the stored high byte so the
  // field can be judged on the same edge that accepts it.
  assign tl_full = {tl_q[15:8], data};

  assign size_ok = (cnt_q >= MIN_CNT) && (cnt_q <= MAX_CNT) &&
                   (!len_mode_q || (16'(cnt_q) >= tl_q));

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    tl_d       = tl_q;
    len_mode_d = len_mode_q;
    data_d     = data_q;
    dst_d      = 1'b0;
    src_d      = 1'b0;
    type_d     = 1'b0;
    pay_d      = 1'b0;
    tlv_d      = tlv_q;
    psv_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (control) begin
          state_d    = DST;
          hdr_cnt_d  = 4'd1;
          data_d     = data;
          dst_d      = 1'b1;
          cnt_d      = '0;
          tlv_d      = 1'b0;
          len_mode_d = 1'b0;
        end
      end

      DST: begin
        if (control) begin
          data_d    = data;
          dst_d     = 1'b1;
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q == LAST_DST) state_d = SRC;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      SRC: begin
        if (control) begin
          data_d    = data;
          src_d     = 1'b1;
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q == LAST_SRC) state_d = TYPE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      TYPE: begin
        if (control) begin
          data_d    = data;
          type_d    = 1'b1;
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q == TYPE_HI) begin
            tl_d[15:8] = data;
          end else begin
            tl_d = tl_full;
            if (tl_full <= MAX_TL) begin
              len_mode_d = 1'b1;
              tlv_d      = 1'b1;
              state_d    = PAYLOAD;
            end else if (tl_full >= ETYPE_MIN) begin
              len_mode_d = 1'b0;
              tlv_d      = 1'b1;
              state_d    = PAYLOAD;
            end else begin
              err_d   = 1'b1;
              state_d = DROP;
            end
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      PAYLOAD: begin
        if (control) begin
          // Byte that would exceed the maximum is refused; count stays saturated.
          if (cnt_q == MAX_CNT) begin
            err_d   = 1'b1;
            state_d = DROP;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            data_d = data;
            pay_d  = 1'b1;
          end
        end else begin
          if (size_ok) begin
            psv_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      DROP: begin
        if (!control) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hdr_cnt_q  <= '0;
      tl_q       <= '0;
      len_mode_q <= 1'b0;
      data_q     <= '0;
      dst_q      <= 1'b0;
      src_q      <= 1'b0;
      type_q     <= 1'b0;
      pay_q      <= 1'b0;
      tlv_q      <= 1'b0;
      psv_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      tl_q       <= tl_d;
      len_mode_q <= len_mode_d;
      data_q     <= data_d;
      dst_q      <= dst_d;
      src_q      <= src_d;
      type_q     <= type_d;
      pay_q      <= pay_d;
      tlv_q      <= tlv_d;
      psv_q      <= psv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign data_out          = data_q;
  assign dst_en            = dst_q;
  assign src_en            = src_q;
  assign type_en           = type_q;
  assign payload_en        = pay_q;
  assign type_length_valid = tlv_q;
  assign packet_size_valid = psv_q;
  assign frame_done        = done_q;
  assign frame_error       = err_q;
  assign payload_count     = cnt_q;

endmodule

// File: tb/tb_eth_frame_sequencer.sv
// Directed bench for eth_frame_sequencer: drives whole frames and checks
// per-frame strobe counts, qualifiers and pulses against hand-derived values.
module tb_eth_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        control = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [7:0]  data_out;
  logic        dst_en, src_en, type_en, payload_en;
  logic        type_length_valid, packet_size_valid, frame_done, frame_error;
  logic [10:0] payload_count;

  eth_frame_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .control           (control),
    .data              (data),
    .data_out          (data_out),
    .dst_en            (dst_en),
    .src_en            (src_en),
    .type_en           (type_en),
    .payload_en        (payload_en),
    .type_length_valid (type_length_valid),
    .packet_size_valid (packet_size_valid),
    .frame_done        (frame_done),
    .frame_error       (frame_error),
    .payload_count     (payload_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  int n_dst, n_src, n_type, n_pay, n_err, n_done, n_psv, n_pair, n_multi, n_dbad;
  int tlv_t1, tlv_t2, err_t2, err_pay_idx, pay_idx, pcount_end;
  logic [7:0] cur_byte;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int out_vec();
    return int'({data_out, dst_en, src_en, type_en, payload_en, type_length_valid,
                 packet_size_valid, frame_done, frame_error, payload_count});
  endfunction

  task automatic step(input logic ctl, input logic [7:0] d);
    control  = ctl;
    data     = d;
    cur_byte = d;
    @(posedge clock);
    #1;
  endtask

  task automatic tally();
    int s;
    s = int'(dst_en) + int'(src_en) + int'(type_en) + int'(payload_en);
    if (s > 1) n_multi++;
    if (s != 0 && data_out !== cur_byte) n_dbad++;
    n_dst  += int'(dst_en);
    n_src  += int'(src_en);
    n_type += int'(type_en);
    n_pay  += int'(payload_en);
    n_err  += int'(frame_error);
    n_done += int'(frame_done);
    n_psv  += int'(packet_size_valid);
    n_pair += int'(frame_done && packet_size_valid);
    if (frame_error && err_pay_idx < 0 && pay_idx >= 0) err_pay_idx = pay_idx;
  endtask

  task automatic run_frame(input int nhdr, input logic [15:0] tl, input int npay);
    logic [7:0] b;
    n_dst = 0; n_src = 0; n_type = 0; n_pay = 0; n_err = 0; n_done = 0;
    n_psv = 0; n_pair = 0; n_multi = 0; n_dbad = 0;
    tlv_t1 = -1; tlv_t2 = -1; err_t2 = -1; err_pay_idx = -1; pay_idx = -1;
    for (int i = 0; i < nhdr; i++) begin
      if (i < 12)       b = 8'(i + 160);
      else if (i == 12) b = tl[15:8];
      else              b = tl[7:0];
      step(1'b1, b);
      tally();
      if (i == 12) tlv_t1 = int'(type_length_valid);
      if (i == 13) begin
        tlv_t2 = int'(type_length_valid);
        err_t2 = int'(frame_error);
      end
    end
    for (int p = 0; p < npay; p++) begin
      pay_idx = p;
      step(1'b1, 8'(p * 7 + 3));
      tally();
    end
    pay_idx = -1;
    step(1'b0, 8'h00);
    tally();
    pcount_end = int'(payload_count);
    step(1'b0, 8'h00);
    tally();
  endtask

  task automatic expect_good(input string tag, input int npay);
    check({tag, "_dst"}, n_dst, 6);
    check({tag, "_src"}, n_src, 6);
    check({tag, "_type"}, n_type, 2);
    check({tag, "_pay"}, n_pay, npay);
    check({tag, "_done"}, n_done, 1);
    check({tag, "_psv_with_done"}, n_pair, 1);
    check({tag, "_err"}, n_err, 0);
    check({tag, "_pcount"}, pcount_end, npay);
  endtask

  initial begin
    #3;
    check("reset_outputs_pre_edge", out_vec(), 0);
    #20;
    check("reset_outputs_held", out_vec(), 0);
    reset = 1'b1;
    step(1'b0, 8'h00);
    check("idle_after_release", out_vec(), 0);

    // Minimum EtherType frame
    run_frame(14, 16'h0800, 46);
    expect_good("min", 46);
    check("min_tlv_before_2nd_type", tlv_t1, 0);
    check("min_tlv_with_2nd_type", tlv_t2, 1);
    check("min_psv", n_psv, 1);
    check("min_data_out", n_dbad, 0);
    check("min_onehot", n_multi, 0);
    check("min_tlv_held", int'(type_length_valid), 1);

    // Length mode: 64 declared, 50 delivered
    run_frame(14, 16'h0040, 50);
    check("len_short_err", n_err, 1);
    check("len_short_psv", n_psv, 0);
    check("len_short_done", n_done, 0);
    check("len_short_pay", n_pay, 50);

    // Length mode: 46 declared, 46 delivered
    run_frame(14, 16'h002E, 46);
    expect_good("len_ok", 46);

    // Illegal type/length, then a normal frame
    run_frame(14, 16'h05FF, 60);
    check("illegal_err_at_2nd_type", err_t2, 1);
    check("illegal_err_count", n_err, 1);
    check("illegal_no_payload", n_pay, 0);
    check("illegal_tlv", tlv_t2, 0);
    check("illegal_type_strobes", n_type, 2);
    run_frame(14, 16'h0800, 46);
    expect_good("after_illegal", 46);

    // Oversize payload
    run_frame(14, 16'h0800, 1501);
    check("over_pay", n_pay, 1500);
    check("over_err_index", err_pay_idx, 1500);
    check("over_err_count", n_err, 1);
    check("over_done", n_done, 0);
    check("over_pcount", pcount_end, 1500);
    check("over_onehot", n_multi, 0);

    // Truncated header after byte 9
    run_frame(10, 16'h0000, 0);
    check("trunc_dst", n_dst, 6);
    check("trunc_src", n_src, 4);
    check("trunc_err", n_err, 1);
    check("trunc_type", n_type, 0);
    run_frame(14, 16'h0800, 46);
    expect_good("after_trunc", 46);

    // Asynchronous reset in the middle of a payload
    for (int i = 0; i < 14; i++) step(1'b1, 8'(i));
    for (int p = 0; p < 20; p++) step(1'b1, 8'(p + 1));
    check("midreset_pre_count", int'(payload_count), 20);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_outputs", out_vec(), 0);
    #7;
    reset = 1'b1;
    step(1'b0, 8'h00);
    check("midreset_idle", out_vec(), 0);
    run_frame(14, 16'h0800, 46);
    expect_good("after_reset", 46);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
